// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, immediate formats and the ID/EX control bundle.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate encodings; IMM_NONE yields a zero immediate.
  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  // Control bits carried from ID into EX.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
    logic illegal;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; all formats sign-extend from instr[31].
module imm_gen
  import rv32_pkg::*;
(
  input  logic      [31:0] instr,
  input  imm_type_e        imm_type,
  output logic      [31:0] imm
);

  // Reassemble the scattered immediate bits for the selected format.
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register-file addressing, WB bypass,
// immediate/control decode, load-use hazard detection and the ID/EX register.
//
// Flow control: a slot moves from IF/ID into ID/EX on every rising edge unless
// stall is 1; stall holds IF/ID and inserts a bubble (id_ex_valid=0, controls 0).
// flush squashes the ID slot, wins over stall and forces stall low.
module id_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
)
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  output logic            stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [6:0]      id_ex_opcode,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b5,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic            id_ex_alu_src,
  output logic            id_ex_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  imm_type_e       imm_type;
  logic [XLEN-1:0] imm;
  logic            uses_rs1;
  logic            uses_rs2;
  id_ex_ctrl_t     dec_ctrl;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            hazard;

  logic            valid_d,    valid_q;
  id_ex_ctrl_t     ctrl_d,     ctrl_q;
  logic [XLEN-1:0] pc_d,       pc_q;
  logic [XLEN-1:0] imm_d,      imm_q;
  logic [XLEN-1:0] rs1_data_d, rs1_data_q;
  logic [XLEN-1:0] rs2_data_d, rs2_data_q;
  logic [4:0]      rs1_d,      rs1_q;
  logic [4:0]      rs2_d,      rs2_q;
  logic [4:0]      rd_d,       rd_q;
  logic [6:0]      opcode_d,   opcode_q;
  logic [2:0]      funct3_d,   funct3_q;
  logic            funct7b5_d, funct7b5_q;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rf_rs1 = if_instr[19:15];
  assign rf_rs2 = if_instr[24:20];

  imm_gen u_imm_gen (
    .instr    (if_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  // Opcode decode: immediate format, source usage and control bits.
  always_comb begin
    dec_ctrl = CTRL_NONE;
    imm_type = IMM_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        imm_type           = IMM_U;
      end
      OPC_JAL: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.jump      = 1'b1;
        imm_type           = IMM_J;
      end
      OPC_JALR: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.jump      = 1'b1;
        uses_rs1           = 1'b1;
        imm_type           = IMM_I;
      end
      OPC_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        imm_type        = IMM_B;
      end
      OPC_LOAD: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.mem_read  = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        uses_rs1           = 1'b1;
        imm_type           = IMM_I;
      end
      OPC_STORE: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        uses_rs1           = 1'b1;
        uses_rs2           = 1'b1;
        imm_type           = IMM_S;
      end
      OPC_OP_IMM: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        uses_rs1           = 1'b1;
        imm_type           = IMM_I;
      end
      OPC_OP: begin
        dec_ctrl.reg_write = 1'b1;
        uses_rs1           = 1'b1;
        uses_rs2           = 1'b1;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded, so never request one.
    if (rd == 5'd0) dec_ctrl.reg_write = 1'b0;
  end

  // Operand read with same-cycle WB bypass; x0 is hardwired to zero.
  always_comb begin
    rs1_data = rf_read_data1;
    rs2_data = rf_read_data2;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rf_rs1)) rs1_data = wb_data;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rf_rs2)) rs2_data = wb_data;
    if (rf_rs1 == 5'd0) rs1_data = '0;
    if (rf_rs2 == 5'd0) rs2_data = '0;
  end

  // Load-use hazard: the load in EX produces a register this instruction reads.
  always_comb begin
    hazard = if_valid && ex_mem_read && (ex_rd != 5'd0) &&
             ((uses_rs1 && (ex_rd == rf_rs1)) || (uses_rs2 && (ex_rd == rf_rs2)));
    stall  = hazard && !flush;
  end

  // ID/EX next state: flush, then stall bubble, then normal capture.
  always_comb begin
    pc_d       = if_pc;
    imm_d      = imm;
    rs1_data_d = rs1_data;
    rs2_data_d = rs2_data;
    rs1_d      = rf_rs1;
    rs2_d      = rf_rs2;
    rd_d       = rd;
    opcode_d   = opcode;
    funct3_d   = funct3;
    funct7b5_d = if_instr[30];
    valid_d    = if_valid;
    ctrl_d     = if_valid ? dec_ctrl : CTRL_NONE;
    if (flush || stall) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NONE;
    end
  end

  // ID/EX pipeline register; reset clears every field.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_NONE;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
    end
  end

  assign id_ex_valid     = valid_q;
  assign id_ex_pc        = pc_q;
  assign id_ex_imm       = imm_q;
  assign id_ex_rs1_data  = rs1_data_q;
  assign id_ex_rs2_data  = rs2_data_q;
  assign id_ex_rs1       = rs1_q;
  assign id_ex_rs2       = rs2_q;
  assign id_ex_rd        = rd_q;
  assign id_ex_opcode    = opcode_q;
  assign id_ex_funct3    = funct3_q;
  assign id_ex_funct7b5  = funct7b5_q;
  assign id_ex_reg_write = ctrl_q.reg_write;
  assign id_ex_mem_read  = ctrl_q.mem_read;
  assign id_ex_mem_write = ctrl_q.mem_write;
  assign id_ex_branch    = ctrl_q.branch;
  assign id_ex_jump      = ctrl_q.jump;
  assign id_ex_alu_src   = ctrl_q.alu_src;
  assign id_ex_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed cases followed by randomized instruction streams
// checked against a behavioural decode model.
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic        full;      // datapath fields defined (not a bubble)
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  ctl;       // {reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        stall;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_imm, id_ex_rs1_data, id_ex_rs2_data;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [6:0]  id_ex_opcode;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic        id_ex_branch, id_ex_jump, id_ex_alu_src, id_ex_illegal;

  logic [31:0] rf_mem [32];
  exp_t        exp_q [$];
  int          errors = 0;
  int          checks = 0;

  assign rf_read_data1 = rf_mem[rf_rs1];
  assign rf_read_data2 = rf_mem[rf_rs2];

  id_stage #(.XLEN(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .flush           (flush),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .wb_reg_write    (wb_reg_write),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .rf_rs1          (rf_rs1),
    .rf_rs2          (rf_rs2),
    .rf_read_data1   (rf_read_data1),
    .rf_read_data2   (rf_read_data2),
    .stall           (stall),
    .id_ex_valid     (id_ex_valid),
    .id_ex_pc        (id_ex_pc),
    .id_ex_imm       (id_ex_imm),
    .id_ex_rs1_data  (id_ex_rs1_data),
    .id_ex_rs2_data  (id_ex_rs2_data),
    .id_ex_rs1       (id_ex_rs1),
    .id_ex_rs2       (id_ex_rs2),
    .id_ex_rd        (id_ex_rd),
    .id_ex_opcode    (id_ex_opcode),
    .id_ex_funct3    (id_ex_funct3),
    .id_ex_funct7b5  (id_ex_funct7b5),
    .id_ex_reg_write (id_ex_reg_write),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_mem_write (id_ex_mem_write),
    .id_ex_branch    (id_ex_branch),
    .id_ex_jump      (id_ex_jump),
    .id_ex_alu_src   (id_ex_alu_src),
    .id_ex_illegal   (id_ex_illegal)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Decode straight from the ISA tables: immediates built arithmetically.
  function automatic void spec_decode(input logic [31:0] ins, output logic [31:0] imm,
                                      output logic u1, output logic u2, output logic [6:0] ctl);
    logic rw, mr, mw, br, jp, as, il;
    int   s12, s13, s21;
    s12 = ins[31] ? -2048 : 0;
    s13 = ins[31] ? -4096 : 0;
    s21 = ins[31] ? -1048576 : 0;
    {rw, mr, mw, br, jp, as, il} = 7'b0;
    imm = 32'd0; u1 = 1'b0; u2 = 1'b0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin rw = 1; as = 1; imm = ins & 32'hFFFFF000; end
      7'b1101111: begin
        rw = 1; as = 1; jp = 1;
        imm = 32'(s21 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
      end
      7'b1100111: begin rw = 1; as = 1; jp = 1; u1 = 1; imm = 32'(s12 + int'(ins[30:20])); end
      7'b1100011: begin
        br = 1; u1 = 1; u2 = 1;
        imm = 32'(s13 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
      end
      7'b0000011: begin rw = 1; mr = 1; as = 1; u1 = 1; imm = 32'(s12 + int'(ins[30:20])); end
      7'b0100011: begin
        mw = 1; as = 1; u1 = 1; u2 = 1;
        imm = 32'(s12 + int'(ins[30:25]) * 32 + int'(ins[11:7]));
      end
      7'b0010011: begin rw = 1; as = 1; u1 = 1; imm = 32'(s12 + int'(ins[30:20])); end
      7'b0110011: begin rw = 1; u1 = 1; u2 = 1; end
      default:    il = 1;
    endcase
    if (ins[11:7] == 5'd0) rw = 0;
    ctl = {rw, mr, mw, br, jp, as, il};
  endfunction

  // Register value ID should see, including a write landing this cycle.
  function automatic logic [31:0] read_model(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_reg_write && wb_rd == r) return wb_data;
    return rf_mem[r];
  endfunction

  // Drive one cycle, check combinational outputs, then check ID/EX after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic emr, input logic [4:0] erd,
                      input logic wbw, input logic [4:0] wrd, input logic [31:0] wdat);
    logic [31:0] imm;
    logic        u1, u2, exp_stall;
    logic [6:0]  ctl;
    exp_t        e, o;
    @(negedge clk);
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    ex_mem_read = emr; ex_rd = erd;
    wb_reg_write = wbw; wb_rd = wrd; wb_data = wdat;
    #1;
    spec_decode(ins, imm, u1, u2, ctl);
    exp_stall = v && emr && (erd != 0) && !fl &&
                ((u1 && erd == ins[19:15]) || (u2 && erd == ins[24:20]));
    chk("rf_rs1", {27'd0, rf_rs1}, {27'd0, ins[19:15]});
    chk("rf_rs2", {27'd0, rf_rs2}, {27'd0, ins[24:20]});
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    e = '0;
    if (!fl && !exp_stall) begin
      e.valid = v;
      e.full  = 1'b1;
      e.pc    = pc;
      e.imm   = imm;
      e.d1    = read_model(ins[19:15]);
      e.d2    = read_model(ins[24:20]);
      e.rs1   = ins[19:15];
      e.rs2   = ins[24:20];
      e.rd    = ins[11:7];
      e.opc   = ins[6:0];
      e.f3    = ins[14:12];
      e.f7    = ins[30];
      e.ctl   = v ? ctl : 7'd0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (wbw && wrd != 0) rf_mem[wrd] = wdat;
    o = exp_q.pop_front();
    chk("valid", {31'd0, id_ex_valid}, {31'd0, o.valid});
    chk("ctrl", {25'd0, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch,
                 id_ex_jump, id_ex_alu_src, id_ex_illegal}, {25'd0, o.ctl});
    if (o.full) begin
      chk("pc", id_ex_pc, o.pc);
      chk("imm", id_ex_imm, o.imm);
      chk("rs1_data", id_ex_rs1_data, o.d1);
      chk("rs2_data", id_ex_rs2_data, o.d2);
      chk("regs", {17'd0, id_ex_rs1, id_ex_rs2, id_ex_rd}, {17'd0, o.rs1, o.rs2, o.rd});
      chk("fields", {21'd0, id_ex_opcode, id_ex_funct3, id_ex_funct7b5},
          {21'd0, o.opc, o.f3, o.f7});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, id_ex_valid}, 32'd0);
    chk({tag, "_pc"}, id_ex_pc, 32'd0);
    chk({tag, "_imm"}, id_ex_imm, 32'd0);
    chk({tag, "_data"}, id_ex_rs1_data | id_ex_rs2_data, 32'd0);
    chk({tag, "_idx"}, {17'd0, id_ex_rs1, id_ex_rs2, id_ex_rd}, 32'd0);
    chk({tag, "_fields"}, {21'd0, id_ex_opcode, id_ex_funct3, id_ex_funct7b5}, 32'd0);
    chk({tag, "_ctrl"}, {25'd0, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
        id_ex_branch, id_ex_jump, id_ex_alu_src, id_ex_illegal}, 32'd0);
  endtask

  logic [6:0] opc_tab [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};

  initial begin
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'hDEADBEEF;  // x0 must never leak this value
    reset_n = 1'b0; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0;
    ex_mem_read = 0; ex_rd = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // addi x5,x0,123
    step(1, 32'h07B00293, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("addi_imm", id_ex_imm, 32'd123);
    chk("addi_rd", {27'd0, id_ex_rd}, 32'd5);
    chk("addi_rw_as", {30'd0, id_ex_reg_write, id_ex_alu_src}, 32'd3);
    chk("addi_rs1_data", id_ex_rs1_data, 32'd0);
    // sw x5,-4(x2)
    step(1, 32'hFE512E23, 32'h104, 0, 0, 0, 0, 0, 0);
    chk("sw_imm", id_ex_imm, 32'hFFFFFFFC);
    chk("sw_mw_rw", {30'd0, id_ex_mem_write, id_ex_reg_write}, 32'd2);
    chk("sw_rs2", {27'd0, id_ex_rs2}, 32'd5);
    // add x7,x6,x5 behind lw x6: one bubble, then issue
    step(1, 32'h005303B3, 32'h108, 0, 1, 6, 0, 0, 0);
    chk("hazard_bubble", {31'd0, id_ex_valid}, 32'd0);
    step(1, 32'h005303B3, 32'h108, 0, 0, 6, 0, 0, 0);
    chk("hazard_issue", {31'd0, id_ex_valid}, 32'd1);
    // WB bypass of x5, then a write to x0 that must not bypass
    rf_mem[5] = 32'd0;
    step(1, 32'h005303B3, 32'h10C, 0, 0, 0, 1, 5, 123);
    chk("bypass_rs2", id_ex_rs2_data, 32'd123);
    rf_mem[5] = 32'd0;
    step(1, 32'h005303B3, 32'h110, 0, 0, 0, 1, 0, 123);
    chk("no_bypass_x0", id_ex_rs2_data, 32'd0);
    // flush together with a hazard
    step(1, 32'h005303B3, 32'h114, 1, 1, 6, 0, 0, 0);
    // illegal opcode 0x7F
    step(1, 32'h0000007F, 32'h118, 0, 0, 0, 0, 0, 0);
    chk("illegal", {25'd0, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch,
        id_ex_jump, id_ex_alu_src, id_ex_illegal}, 32'd1);

    // Random stream with a small register window to provoke hazards and bypasses.
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0]   = opc_tab[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 7) != 0), ins, $urandom, ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    // Asynchronous reset between edges drops the captured instruction.
    step(1, 32'h07B00293, 32'h200, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_valid", {31'd0, id_ex_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 32'hFE512E23, 32'h204, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
